xbar_access_ctrl: RTL

Single-cell access sequencer for the 64x64 1T1R memristor crossbar array. It accepts one READ, SET or RESET command at a time for a (row, column) cell and drives the array's row, column and weight-polarity vectors through timed pulse, settle and sense phases. SET/RESET use program-and-verify with bounded retries. Results return on a valid/ready response channel. It sits between the host/weight-loader logic and the crossbar array instance.

---
 rtl/xbar_access_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/xbar_access_ctrl.sv
// Single-cell access sequencer for a 64x64 1T1R crossbar: READ, or SET/RESET with program-and-verify.
// Drives one-hot row/column pulses and returns the sensed bit on a valid/ready response channel.
module xbar_access_ctrl #(
    parameter int unsigned PULSE_CYC  = 4,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned READ_CYC   = 2,
    parameter int unsigned MAX_RETRY  = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_row,
    input  logic [5:0]  cmd_col,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_data,
    output logic        rsp_err,
    output logic [3:0]  rsp_tries,
    output logic [63:0] xbar_row,
    output logic [63:0] xbar_col,
    output logic [63:0] xbar_wctl,
    input  logic [63:0] xbar_sense
);

    localparam int unsigned N  = 64;
    localparam int unsigned IW = 6;
    localparam int unsigned TW = 8;
    localparam int unsigned CW = 4;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_RESET = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_SETTLE,
        S_SENSE,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [IW-1:0]   row_q, row_d;
    logic [IW-1:0]   col_q, col_d;
    logic [1:0]      op_q, op_d;
    logic [CW-1:0]   tries_q, tries_d;
    logic            data_q, data_d;
    logic            err_q, err_d;
    logic            valid_q, valid_d;
    logic [N-1:0]    xrow_q, xrow_d;
    logic [N-1:0]    xcol_q, xcol_d;
    logic [N-1:0]    xwctl_q, xwctl_d;
    logic            drive_d;
    logic            positive_d;
    logic            sensed;

    assign sensed = xbar_sense[col_q];

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            op_q    <= OP_READ;
            tries_q <= '0;
            data_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            xrow_q  <= '0;
            xcol_q  <= '0;
            xwctl_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            row_q   <= row_d;
            col_q   <= col_d;
            op_q    <= op_d;
            tries_q <= tries_d;
            data_q  <= data_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            xrow_q  <= xrow_d;
            xcol_q  <= xcol_d;
            xwctl_q <= xwctl_d;
        end
    end

    // Next-state, phase timer and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        row_d   = row_q;
        col_d   = col_q;
        op_d    = op_q;
        tries_d = tries_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    row_d   = cmd_row;
                    col_d   = cmd_col;
                    op_d    = cmd_op;
                    tries_d = '0;
                    data_d  = 1'b0;
                    err_d   = 1'b0;
                    case (cmd_op)
                        OP_READ: begin
                            state_d = S_SENSE;
                            timer_d = TW'(READ_CYC - 1);
                        end
                        OP_SET, OP_RESET: begin
                            state_d = S_PULSE;
                            timer_d = TW'(PULSE_CYC - 1);
                            tries_d = CW'(1);
                        end
                        default: begin
                            state_d = S_RESP;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_PULSE: begin
                if (timer_q == '0) begin
                    state_d = S_SETTLE;
                    timer_d = TW'(SETTLE_CYC - 1);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = S_SENSE;
                    timer_d = TW'(READ_CYC - 1);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_SENSE: begin
                if (timer_q == '0) begin
                    data_d = sensed;
                    // SET verifies toward 1, RESET toward 0; retry while budget remains.
                    if (op_q == OP_READ || sensed == (op_q == OP_SET)) begin
                        state_d = S_RESP;
                    end else if (32'(tries_q) <= MAX_RETRY) begin
                        tries_d = tries_q + CW'(1);
                        state_d = S_PULSE;
                        timer_d = TW'(PULSE_CYC - 1);
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        drive_d    = (state_d == S_PULSE) || (state_d == S_SENSE);
        positive_d = (state_d == S_SENSE) || (op_d == OP_SET);
        xrow_d     = drive_d ? (N'(1) << row_d) : '0;
        xcol_d     = drive_d ? (N'(1) << col_d) : '0;
        xwctl_d    = (drive_d && positive_d) ? (N'(1) << row_d) : '0;
        valid_d    = (state_d == S_RESP);
    end

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = valid_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign rsp_tries = tries_q;
    assign xbar_row  = xrow_q;
    assign xbar_col  = xcol_q;
    assign xbar_wctl = xwctl_q;

endmodule
